// File: rtl/arch_mem_pkg.sv
// Shared constants for the memory slot arbiter:
// FSM encoding, Wishbone CTI codes and DMA channel indices.
package arch_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_DMA  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int CH_VID = 0;
  localparam int CH_CUR = 1;
  localparam int CH_SND = 2;
  localparam int PK_CPU = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker for the memory slot.
// One-hot result: bits 2:0 follow the DMA channel index, bit 3 is CPU.
module mem_arb_pick
  import arch_mem_pkg::*;
(
  input  logic       token_i,
  input  logic       cpu_req_i,
  input  logic [2:0] dma_req_i,
  output logic [3:0] pick_o
);

  always_comb begin
    pick_o = 4'b0000;
    if (token_i && cpu_req_i) begin
      pick_o[PK_CPU] = 1'b1;
    end else if (dma_req_i[CH_SND]) begin
      pick_o[CH_SND] = 1'b1;
    end else if (dma_req_i[CH_VID]) begin
      pick_o[CH_VID] = 1'b1;
    end else if (dma_req_i[CH_CUR]) begin
      pick_o[CH_CUR] = 1'b1;
    end else if (cpu_req_i) begin
      pick_o[PK_CPU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Shares the external Wishbone memory port between single CPU beats
// and fixed-length DMA bursts, with a CPU fairness token between bursts.
module mem_slot_arbiter
  import arch_mem_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int AW        = 22
) (
  input  logic          clkcpu,
  input  logic          rst_n_i,
  input  logic          cpu_cyc_i,
  input  logic          cpu_stb_i,
  input  logic          cpu_we_i,
  input  logic [3:0]    cpu_sel_i,
  input  logic [AW-1:0] cpu_adr_i,
  output logic          cpu_ack_o,
  input  logic [2:0]    dma_req_i,
  input  logic [AW-1:0] vid_adr_i,
  input  logic [AW-1:0] cur_adr_i,
  input  logic [AW-1:0] snd_adr_i,
  output logic [2:0]    dma_gnt_o,
  output logic [2:0]    dma_ack_o,
  output logic          mem_cyc_o,
  output logic          mem_stb_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_sel_o,
  output logic [2:0]    mem_cti_o,
  output logic [AW-1:0] mem_adr_o,
  input  logic          mem_ack_i
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic          token_q, token_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [2:0]    cti_q, cti_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [2:0]    gnt_q, gnt_d;

  logic       cpu_req;
  logic [3:0] pick;

  assign cpu_req = cpu_cyc_i & cpu_stb_i;

  mem_arb_pick u_pick (
    .token_i   (token_q),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req_i),
    .pick_o    (pick)
  );

  always_comb begin
    state_d = state_q;
    token_d = token_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cti_d   = cti_q;
    adr_d   = adr_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[PK_CPU]) begin
          state_d = ST_CPU;
          cyc_d   = 1'b1;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          adr_d   = cpu_adr_i;
          cti_d   = CTI_CLASSIC;
          gnt_d   = 3'b000;
        end else if (|pick[2:0]) begin
          state_d = ST_DMA;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          cti_d   = CTI_INCR;
          gnt_d   = pick[2:0];
          beat_d  = '0;
          if (pick[CH_SND])      adr_d = snd_adr_i;
          else if (pick[CH_CUR]) adr_d = cur_adr_i;
          else                   adr_d = vid_adr_i;
        end
      end
      ST_CPU: begin
        if (mem_ack_i) begin
          state_d = ST_GAP;
          token_d = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          cti_d   = CTI_CLASSIC;
          adr_d   = '0;
        end
      end
      ST_DMA: begin
        if (mem_ack_i) begin
          if (beat_q == LAST) begin
            state_d = ST_GAP;
            token_d = 1'b1;
            cyc_d   = 1'b0;
            sel_d   = 4'h0;
            cti_d   = CTI_CLASSIC;
            adr_d   = '0;
            gnt_d   = 3'b000;
          end else begin
            beat_d = beat_q + 1'b1;
            adr_d  = adr_q + AW'(1);
            cti_d  = (beat_d == LAST) ? CTI_EOB : CTI_INCR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkcpu or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      token_q <= 1'b0;
      beat_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      cti_q   <= CTI_CLASSIC;
      adr_q   <= '0;
      gnt_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      token_q <= token_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cti_q   <= cti_d;
      adr_q   <= adr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Acks are steered straight from the memory so data is taken the same cycle
  assign cpu_ack_o = (state_q == ST_CPU) & mem_ack_i;
  assign dma_ack_o = ((state_q == ST_DMA) && mem_ack_i) ? gnt_q : 3'b000;

  assign dma_gnt_o = gnt_q;
  assign mem_cyc_o = cyc_q;
  assign mem_stb_o = cyc_q;
  assign mem_we_o  = we_q;
  assign mem_sel_o = sel_q;
  assign mem_cti_o = cti_q;
  assign mem_adr_o = adr_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter: vector table plus
// hand-written sequences for priority/token and async reset.
module tb_mem_slot_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_cyc_i = 1'b0;
  logic        cpu_stb_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = 4'h0;
  logic [21:0] cpu_adr_i = '0;
  logic        cpu_ack_o;
  logic [2:0]  dma_req_i = 3'b000;
  logic [21:0] vid_adr_i = 22'h3FFFFE;
  logic [21:0] cur_adr_i = 22'h002000;
  logic [21:0] snd_adr_i = 22'h003000;
  logic [2:0]  dma_gnt_o;
  logic [2:0]  dma_ack_o;
  logic        mem_cyc_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [2:0]  mem_cti_o;
  logic [21:0] mem_adr_o;
  logic        mem_ack_i = 1'b0;

  always #5 clk = ~clk;

  mem_slot_arbiter #(.BURST_LEN(4), .AW(22)) dut (
    .clkcpu    (clk),
    .rst_n_i   (rst_n),
    .cpu_cyc_i (cpu_cyc_i),
    .cpu_stb_i (cpu_stb_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_adr_i (cpu_adr_i),
    .cpu_ack_o (cpu_ack_o),
    .dma_req_i (dma_req_i),
    .vid_adr_i (vid_adr_i),
    .cur_adr_i (cur_adr_i),
    .snd_adr_i (snd_adr_i),
    .dma_gnt_o (dma_gnt_o),
    .dma_ack_o (dma_ack_o),
    .mem_cyc_o (mem_cyc_o),
    .mem_stb_o (mem_stb_o),
    .mem_we_o  (mem_we_o),
    .mem_sel_o (mem_sel_o),
    .mem_cti_o (mem_cti_o),
    .mem_adr_o (mem_adr_o),
    .mem_ack_i (mem_ack_i)
  );

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic        creq;
    logic [2:0]  dreq;
    logic        ack;
    logic        e_cack;
    logic [2:0]  e_gnt;
    logic [2:0]  e_dack;
    logic        e_cyc;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic [21:0] e_adr;
  } vec_t;

  vec_t tv[19];

  function automatic logic [38:0] obs();
    return {cpu_ack_o, dma_gnt_o, dma_ack_o, mem_cyc_o, mem_stb_o,
            mem_we_o, mem_sel_o, mem_cti_o, mem_adr_o};
  endfunction

  function automatic logic [38:0] expv(
    input logic cack, input logic [2:0] gnt, input logic [2:0] dack,
    input logic cyc, input logic we, input logic [3:0] sel,
    input logic [2:0] cti, input logic [21:0] adr);
    return {cack, gnt, dack, cyc, cyc, we, sel, cti, adr};
  endfunction

  function automatic vec_t mk(
    input logic creq, input logic [2:0] dreq, input logic ack,
    input logic cack, input logic [2:0] gnt, input logic [2:0] dack,
    input logic cyc, input logic [3:0] sel, input logic [2:0] cti,
    input logic [21:0] adr);
    vec_t v;
    v.creq = creq; v.dreq = dreq; v.ack = ack;
    v.e_cack = cack; v.e_gnt = gnt; v.e_dack = dack;
    v.e_cyc = cyc; v.e_sel = sel; v.e_cti = cti; v.e_adr = adr;
    return v;
  endfunction

  task automatic check(input string name, input logic [38:0] exp);
    logic [38:0] got;
    got = obs();
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cpu_cyc_i = 1'b0;
    cpu_stb_i = 1'b0;
    dma_req_i = 3'b000;
    mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [2:0] I = 3'b010;
  localparam logic [2:0] E = 3'b111;

  int ev[$];
  int cnt[4];
  logic prev_cyc;
  logic done;
  int g0, g1, g2;

  initial begin
    tv[0]  = mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[1]  = mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 1, 4'hF, 3'b000, 22'h1000);
    tv[2]  = mk(1, 3'b000, 1, 1, 3'b000, 3'b000, 1, 4'hF, 3'b000, 22'h1000);
    tv[3]  = mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[4]  = mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[5]  = mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[6]  = mk(0, 3'b001, 1, 0, 3'b001, 3'b001, 1, 4'hF, I, 22'h3FFFFE);
    tv[7]  = mk(0, 3'b000, 1, 0, 3'b001, 3'b001, 1, 4'hF, I, 22'h3FFFFF);
    tv[8]  = mk(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 4'hF, I, 22'h000000);
    tv[9]  = mk(0, 3'b000, 1, 0, 3'b001, 3'b001, 1, 4'hF, I, 22'h000000);
    tv[10] = mk(0, 3'b000, 1, 0, 3'b001, 3'b001, 1, 4'hF, E, 22'h000001);
    tv[11] = mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[12] = mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[13] = mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[14] = mk(1, 3'b001, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[15] = mk(1, 3'b001, 1, 1, 3'b000, 3'b000, 1, 4'hF, 3'b000, 22'h1000);
    tv[16] = mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[17] = mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 4'h0, 3'b000, 22'h0);
    tv[18] = mk(0, 3'b000, 0, 0, 3'b001, 3'b000, 1, 4'hF, I, 22'h3FFFFE);

    // reset state, then the vector table
    @(negedge clk);
    #1;
    check("reset", 39'h0);
    reset_dut();
    cpu_we_i  = 1'b0;
    cpu_sel_i = 4'hF;
    cpu_adr_i = 22'h1000;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      cpu_cyc_i = tv[i].creq;
      cpu_stb_i = tv[i].creq;
      dma_req_i = tv[i].dreq;
      mem_ack_i = tv[i].ack;
      #1;
      check($sformatf("vec%0d", i),
            expv(tv[i].e_cack, tv[i].e_gnt, tv[i].e_dack, tv[i].e_cyc,
                 1'b0, tv[i].e_sel, tv[i].e_cti, tv[i].e_adr));
    end

    // sound, video and CPU requested together
    reset_dut();
    @(negedge clk);
    cpu_cyc_i = 1'b1;
    cpu_stb_i = 1'b1;
    cpu_we_i  = 1'b1;
    cpu_sel_i = 4'h3;
    cpu_adr_i = 22'h1000;
    dma_req_i = 3'b101;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    prev_cyc = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      mem_ack_i = mem_cyc_o;
      #1;
      if (mem_cyc_o && !prev_cyc) begin
        if (dma_gnt_o == 3'b000) begin
          ev.push_back(3);
          n_run++;
          if (mem_we_o !== 1'b1 || mem_sel_o !== 4'h3) begin
            n_fail++;
            $display("FAIL cpu_slot_attr: we %b sel %h want we 1 sel 3",
                     mem_we_o, mem_sel_o);
          end
        end else if (dma_gnt_o[2]) ev.push_back(2);
        else if (dma_gnt_o[1]) ev.push_back(1);
        else ev.push_back(0);
      end
      prev_cyc = mem_cyc_o;
      if (cpu_ack_o) begin
        cnt[3]++;
        cpu_cyc_i = 1'b0;
        cpu_stb_i = 1'b0;
      end
      for (int k = 0; k < 3; k++) if (dma_ack_o[k]) cnt[k]++;
      if (dma_gnt_o[2]) dma_req_i[2] = 1'b0;
      if (dma_gnt_o[0]) dma_req_i[0] = 1'b0;
      if (ev.size() >= 3 && !mem_cyc_o) done = 1'b1;
    end
    mem_ack_i = 1'b0;
    n_run++;
    if (!done) begin
      n_fail++;
      $display("FAIL prio_timeout: done %b events %0d want 3", done, ev.size());
    end
    g0 = (ev.size() > 0) ? ev[0] : -1;
    g1 = (ev.size() > 1) ? ev[1] : -1;
    g2 = (ev.size() > 2) ? ev[2] : -1;
    n_run++;
    if (ev.size() != 3 || g0 != 2 || g1 != 3 || g2 != 0) begin
      n_fail++;
      $display("FAIL prio_order: got n=%0d %0d,%0d,%0d want n=3 2,3,0",
               ev.size(), g0, g1, g2);
    end
    n_run++;
    if (cnt[2] != 4 || cnt[0] != 4 || cnt[3] != 1 || cnt[1] != 0) begin
      n_fail++;
      $display("FAIL prio_beats: snd %0d vid %0d cpu %0d cur %0d want 4 4 1 0",
               cnt[2], cnt[0], cnt[3], cnt[1]);
    end

    // async reset in beat 2 of a cursor burst
    reset_dut();
    @(negedge clk);
    dma_req_i = 3'b010;
    @(negedge clk);
    mem_ack_i = 1'b1;
    #1;
    check("cur_b0", expv(0, 3'b010, 3'b010, 1, 0, 4'hF, I, 22'h2000));
    @(negedge clk);
    #1;
    check("cur_b1", expv(0, 3'b010, 3'b010, 1, 0, 4'hF, I, 22'h2001));
    @(negedge clk);
    #1;
    check("cur_b2", expv(0, 3'b010, 3'b010, 1, 0, 4'hF, I, 22'h2002));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", 39'h0);
    mem_ack_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("cur_fresh", expv(0, 3'b010, 3'b000, 1, 0, 4'hF, I, 22'h2000));
    mem_ack_i = 1'b1;
    #1;
    check("cur_r0", expv(0, 3'b010, 3'b010, 1, 0, 4'hF, I, 22'h2000));
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("cur_r%0d", k),
            expv(0, 3'b010, 3'b010, 1, 0, 4'hF, (k == 3) ? E : I,
                 22'h2000 + 22'(k)));
    end
    dma_req_i = 3'b000;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("cur_gap", 39'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
